// File: rtl/am_demod_if.sv
// Sample/envelope stream bundle for am_demod.
// master: sample source and envelope sink; slave: the demodulator.
interface am_demod_if #(
    parameter int DW = 12
);
    logic                 s_valid;
    logic signed [DW-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-2:0]        m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output m_valid, m_data
    );
endinterface

// File: rtl/am_demod.sv
// AM envelope detector: rectifier, 2^-SHIFT leaky integrator, FILL/RUN FSM, decimated output.
// Define AM_DEMOD_PEAK_EN to add the pk_env peak-hold output.
module am_demod #(
    parameter int DW    = 12,
    parameter int SHIFT = 4,
    parameter int DEC   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    am_demod_if.slave     bus,
    input  logic          clr,
    output logic          overrun,
`ifdef AM_DEMOD_PEAK_EN
    output logic [DW-2:0] pk_env,
`endif
    output logic          busy
);
    localparam int AW  = DW - 1 + SHIFT;
    localparam int DCW = $clog2(DEC + 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t         state;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  acc_nxt;
    logic [DW-1:0]  neg;
    logic [DW-2:0]  r;
    logic [DW-2:0]  env_nxt;
    logic [SHIFT-1:0] fill_cnt;
    logic [DCW-1:0] dec_cnt;
    logic           out_evt;
    logic           m_valid_q;
    logic [DW-2:0]  m_data_q;

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;

    always_comb begin
        neg = -bus.s_data;
        r   = '0;
        if (!bus.s_data[DW-1])
            r = bus.s_data[DW-2:0];
        else if (~|bus.s_data[DW-2:0])
            r = '1;  // most negative sample saturates
        else
            r = neg[DW-2:0];
        // acc never exceeds (2^(DW-1)-1) << SHIFT, so AW bits cannot overflow
        acc_nxt = acc - (acc >> SHIFT) + {{SHIFT{1'b0}}, r};
        env_nxt = acc_nxt[AW-1:SHIFT];
        out_evt = bus.s_valid && (state == RUN) && (dec_cnt == DCW'(DEC - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            acc       <= '0;
            fill_cnt  <= '0;
            dec_cnt   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef AM_DEMOD_PEAK_EN
            pk_env    <= '0;
`endif
        end else begin
            if (bus.s_valid) begin
                acc <= acc_nxt;
                case (state)
                    FILL: begin
                        if (fill_cnt == '1) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            fill_cnt <= '0;
                            dec_cnt  <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + SHIFT'(1);
                        end
                    end
                    RUN: dec_cnt <= out_evt ? '0 : dec_cnt + DCW'(1);
                    default: state <= FILL;
                endcase
            end

            // a new overrun in the same cycle as clr wins
            if (clr)
                overrun <= 1'b0;
            if (out_evt) begin
                if (!m_valid_q || bus.m_ready) begin
                    m_data_q  <= env_nxt;
                    m_valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end

`ifdef AM_DEMOD_PEAK_EN
            if (clr)
                pk_env <= '0;
            else if (bus.s_valid && (state == RUN) && (env_nxt > pk_env))
                pk_env <= env_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_am_demod.sv
// Directed self-checking bench for am_demod (DW=12, SHIFT=4, DEC=8).
// Peak-hold checks compile in when AM_DEMOD_PEAK_EN is defined.
module tb_am_demod;
    localparam int DW    = 12;
    localparam int SHIFT = 4;
    localparam int DEC   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic overrun;
    logic busy;
`ifdef AM_DEMOD_PEAK_EN
    logic [DW-2:0] pk_env;
`endif

    int n_cmp = 0;
    int n_err = 0;

    am_demod_if #(.DW(DW)) bus ();

    am_demod #(.DW(DW), .SHIFT(SHIFT), .DEC(DEC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clr     (clr),
        .overrun (overrun),
`ifdef AM_DEMOD_PEAK_EN
        .pk_env  (pk_env),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n       = 1'b0;
        clr         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [DW-1:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %0b exp 0", bus.m_valid); end
        n_cmp++; if (bus.m_data !== 11'd0) begin n_err++; $display("FAIL reset_m_data got %0d exp 0", bus.m_data); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %0b exp 0", overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy); end
    endtask

    task automatic test_const();
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            send(12'sd1000);
            if (i == 15) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL const_busy15 got %0b exp 0", busy); end
            end
            if (i == 16) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL const_busy16 got %0b exp 1", busy); end
            end
            if (i == 23) begin
                n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL const_valid23 got %0b exp 0", bus.m_valid); end
            end
            if (i == 24) begin
                n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL const_valid24 got %0b exp 1", bus.m_valid); end
            end
            if (i == 25) begin
                n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL const_valid_fall got %0b exp 0", bus.m_valid); end
            end
            if (i == 320 || i == 360 || i == 400) begin
                n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL const_valid_%0d got %0b exp 1", i, bus.m_valid); end
                n_cmp++; if (bus.m_data !== 11'd1000) begin n_err++; $display("FAIL const_data_%0d got %0d exp 1000", i, bus.m_data); end
            end
        end
    endtask

    task automatic test_rectify();
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            send((i % 2) ? 12'sd800 : -12'sd800);
            if (i == 400) begin
                n_cmp++; if (bus.m_data !== 11'd800) begin n_err++; $display("FAIL alt_data got %0d exp 800", bus.m_data); end
            end
        end
        for (int i = 401; i <= 800; i++) begin
            send(-12'sd2048);
            if (i == 792 || i == 800) begin
                n_cmp++; if (bus.m_data !== 11'd2047) begin n_err++; $display("FAIL minneg_data_%0d got %0d exp 2047", i, bus.m_data); end
            end
        end
    endtask

    task automatic test_overrun();
        int acc_m;
        int exp1;
        acc_m = 0;
        for (int i = 0; i < 24; i++)
            acc_m = acc_m - (acc_m >> SHIFT) + 1000;
        exp1 = acc_m >> SHIFT;
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 24; i++) send(12'sd1000);
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got %0b exp 1", bus.m_valid); end
        n_cmp++; if (int'(bus.m_data) !== exp1) begin n_err++; $display("FAIL ovr_first_data got %0d exp %0d", bus.m_data, exp1); end
        for (int i = 25; i <= 31; i++) send(12'sd1000);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early got %0b exp 0", overrun); end
        send(12'sd1000);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got %0b exp 1", overrun); end
        n_cmp++; if (int'(bus.m_data) !== exp1) begin n_err++; $display("FAIL ovr_hold_data got %0d exp %0d", bus.m_data, exp1); end
        clr = 1'b1;
        idle();
        clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr got %0b exp 0", overrun); end
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL ovr_clr_valid got %0b exp 1", bus.m_valid); end
        for (int i = 33; i <= 39; i++) send(12'sd1000);
        clr = 1'b1;
        send(12'sd1000);
        clr = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_clr_coincident got %0b exp 1", overrun); end
        n_cmp++; if (int'(bus.m_data) !== exp1) begin n_err++; $display("FAIL ovr_hold_data2 got %0d exp %0d", bus.m_data, exp1); end
        bus.m_ready = 1'b1;
        idle();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain got %0b exp 0", bus.m_valid); end
    endtask

    task automatic test_midreset();
        logic seen;
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 32; i++) send(12'sd1000);
        n_cmp++; if (bus.m_valid !== 1'b1 || overrun !== 1'b1) begin n_err++; $display("FAIL mid_pre got v=%0b o=%0b exp 1/1", bus.m_valid, overrun); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %0b exp 0", bus.m_valid); end
        n_cmp++; if (bus.m_data !== 11'd0) begin n_err++; $display("FAIL mid_data got %0d exp 0", bus.m_data); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL mid_overrun got %0b exp 0", overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %0b exp 0", busy); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.m_ready = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 23; i++) begin
            send(12'sd1000);
            if (bus.m_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_early_valid got %0b exp 0", seen); end
        send(12'sd1000);
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL mid_first_valid got %0b exp 1", bus.m_valid); end
    endtask

`ifdef AM_DEMOD_PEAK_EN
    task automatic test_peak();
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(12'sd1500);
        n_cmp++; if (pk_env !== 11'd1500) begin n_err++; $display("FAIL pk_settle got %0d exp 1500", pk_env); end
        for (int i = 0; i < 300; i++) send(12'sd500);
        n_cmp++; if (pk_env !== 11'd1500) begin n_err++; $display("FAIL pk_hold got %0d exp 1500", pk_env); end
        clr = 1'b1;
        send(12'sd500);
        clr = 1'b0;
        n_cmp++; if (pk_env !== 11'd0) begin n_err++; $display("FAIL pk_clr_priority got %0d exp 0", pk_env); end
        send(12'sd500);
        n_cmp++; if (pk_env !== 11'd500) begin n_err++; $display("FAIL pk_track got %0d exp 500", pk_env); end
    endtask
`endif

    initial begin
        test_reset();
        test_const();
        test_rectify();
        test_overrun();
        test_midreset();
`ifdef AM_DEMOD_PEAK_EN
        test_peak();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
